// File: rtl/sram_arbiter.sv
// ============================================================================
// Module   : sram_arbiter
// Purpose  : Shares the single 8-bit, 2 MB memory port between the CPU core
//            and the HPS ioctl download path. Loader bytes are written into
//            a window starting at LOAD_BASE with strict priority over the
//            core. The core is stalled for the whole download.
// Ports    : clk_sys, reset        - clock, synchronous active-high reset
//            core_*                - core req/ack port (level req, 1-cycle ack)
//            ioctl_*               - download stream from hps_io
//            mem_*                 - backend command (level req, 1-cycle ack)
//            load_bytes/ovf/sum    - download statistics
// Options  : SRAM_ARB_CHECKSUM_EN  - when defined, load_sum accumulates the
//            in-range bytes of the download. Otherwise load_sum is 16'd0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arbiter #(
  parameter logic [7:0]  LOAD_INDEX = 8'd0,
  parameter logic [20:0] LOAD_BASE  = 21'h1F0000
) (
  input  logic        clk_sys,
  input  logic        reset,
  // core port
  input  logic        core_req,
  input  logic        core_we,
  input  logic [20:0] core_addr,
  input  logic [7:0]  core_din,
  output logic [7:0]  core_dout,
  output logic        core_ack,
  output logic        core_hold,
  // hps_io download port
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [15:0] ioctl_index,
  output logic        ioctl_wait,
  // memory backend
  output logic        mem_req,
  output logic        mem_we,
  output logic [20:0] mem_addr,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout,
  input  logic        mem_ack,
  // download statistics
  output logic [21:0] load_bytes,
  output logic        load_ovf,
  output logic [15:0] load_sum
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CORE = 2'd2;

  logic [1:0]  state_q, state_d;

  logic        dl_active_q;
  logic        hold_q;
  logic        pend_q;
  logic [24:0] pend_addr_q;
  logic [7:0]  pend_data_q;
  logic        core_ack_q;
  logic [7:0]  core_dout_q;
  logic [21:0] bytes_q;
  logic        ovf_q;
  logic        mem_we_q;
  logic [20:0] mem_addr_q;
  logic [7:0]  mem_din_q;

  logic        w_dl_active;
  logic        w_dl_start;
  logic        w_new_wr;
  logic [24:0] w_pend_tgt;
  logic [24:0] w_new_tgt;
  logic        w_pend_ok;
  logic        w_pend_bad;
  logic        w_new_ok;
  logic        w_ld_go;
  logic        w_core_go;
  logic        w_ld_done;
  logic        w_core_done;
  logic        w_mem_req;
  logic        w_unused;

  // Only the low byte of the index selects the download target.
  assign w_unused    = ^ioctl_index[15:8];

  assign w_dl_active = ioctl_download & (ioctl_index[7:0] == LOAD_INDEX);
  assign w_dl_start  = w_dl_active & ~dl_active_q;
  assign w_new_wr    = ioctl_wr & w_dl_active;

  // Full 25-bit sums so that any carry past the 2 MB range is visible.
  assign w_pend_tgt  = {4'd0, LOAD_BASE} + pend_addr_q;
  assign w_new_tgt   = {4'd0, LOAD_BASE} + ioctl_addr;

  assign w_pend_ok   = pend_q & (w_pend_tgt[24:21] == 4'd0);
  assign w_pend_bad  = pend_q & (w_pend_tgt[24:21] != 4'd0);
  // A fresh write is forwarded straight to the backend so that mem_req can
  // rise in the same cycle the slot is marked pending.
  assign w_new_ok    = w_new_wr & ~pend_q & (w_new_tgt[24:21] == 4'd0);

  assign w_ld_go     = w_pend_ok | w_new_ok;
  assign w_core_go   = ~pend_q & core_req & ~core_ack_q & ~hold_q;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (w_ld_go) begin
          state_d = ST_LOAD;
        end else if (w_core_go) begin
          state_d = ST_CORE;
        end
      end
      ST_LOAD: if (mem_ack) state_d = ST_IDLE;
      ST_CORE: if (mem_ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_mem_req   = 1'b0;
    w_ld_done   = 1'b0;
    w_core_done = 1'b0;
    case (state_q)
      ST_LOAD: begin
        w_mem_req = 1'b1;
        w_ld_done = mem_ack;
      end
      ST_CORE: begin
        w_mem_req   = 1'b1;
        w_core_done = mem_ack;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Backend command register: only reloaded when leaving IDLE, so the
  // command stays stable for the whole request.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mem_we_q   <= 1'b0;
      mem_addr_q <= 21'd0;
      mem_din_q  <= 8'd0;
    end else if (state_q == ST_IDLE) begin
      if (w_ld_go) begin
        mem_we_q <= 1'b1;
        if (w_pend_ok) begin
          mem_addr_q <= w_pend_tgt[20:0];
          mem_din_q  <= pend_data_q;
        end else begin
          mem_addr_q <= w_new_tgt[20:0];
          mem_din_q  <= ioctl_dout;
        end
      end else if (w_core_go) begin
        mem_we_q   <= core_we;
        mem_addr_q <= core_addr;
        mem_din_q  <= core_din;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Loader slot, core handshake and statistics
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_active_q <= 1'b0;
      hold_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= 25'd0;
      pend_data_q <= 8'd0;
      core_ack_q  <= 1'b0;
      core_dout_q <= 8'd0;
      bytes_q     <= 22'd0;
      ovf_q       <= 1'b0;
    end else begin
      dl_active_q <= w_dl_active;
      hold_q      <= w_dl_active | pend_q;

      if (w_new_wr) begin
        pend_q      <= 1'b1;
        pend_addr_q <= ioctl_addr;
        pend_data_q <= ioctl_dout;
      end else if (w_pend_bad | w_ld_done) begin
        pend_q <= 1'b0;
      end

      if (w_pend_bad) ovf_q <= 1'b1;
      if (w_ld_done)  bytes_q <= bytes_q + 22'd1;

      core_ack_q <= w_core_done;
      if (w_core_done) core_dout_q <= mem_dout;

      // Start of a new download wins over any update above.
      if (w_dl_start) begin
        bytes_q <= 22'd0;
        ovf_q   <= 1'b0;
      end
    end
  end

`ifdef SRAM_ARB_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sum_q <= 16'd0;
    end else if (w_dl_start) begin
      sum_q <= 16'd0;
    end else if (w_ld_done) begin
      sum_q <= sum_q + {8'd0, pend_data_q};
    end
  end

  assign load_sum = sum_q;
`else
  assign load_sum = 16'd0;
`endif

  assign core_dout  = core_dout_q;
  assign core_ack   = core_ack_q;
  assign core_hold  = hold_q;
  assign ioctl_wait = pend_q;
  assign mem_req    = w_mem_req;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign load_bytes = bytes_q;
  assign load_ovf   = ovf_q;

endmodule

`default_nettype wire
